phy_lane_arbiter: RTL and testbench
===================================

Name: phy_lane_arbiter

Overview:
- Round-robin scheduler that merges the four 8-bit byte lanes (data + valid per lane) onto a single shared byte stream toward the serializer/transmit side of the PHY.
- Each lane has a private FIFO. One clock domain (clk_4f, the byte-lane rate).
- Drives the idle character when no lane has data, and honours downstream backpressure.

Parameters:
- DATA_WIDTH, 8, width of each lane byte and of the output.
- FIFO_DEPTH, 4, entries per lane FIFO. Must be a power of 2 and at least 2.
- IDLE_BYTE, 8'hBC, value driven on data_out whenever valid_out=0.

Ports:
- clk_4f  in  1  single clock. All logic is rising-edge.
- default_values  in  1  reset, synchronous, active-low. Sampled on the clk_4f rising edge.
- data_in0..data_in3  in  DATA_WIDTH  lane bytes.
- valid_in0..valid_in3  in  1  lane byte qualifier, one push per cycle per lane.
- ready  in  1  downstream accepts a byte this cycle.
- data_out  out  DATA_WIDTH  scheduled byte, registered.
- valid_out  out  1  data_out qualifier, registered.
- grant  out  2  lane index of the byte currently on data_out, registered.
- full  out  4  per-lane FIFO full, bit n = lane n. Decoded from the registered count.
- overflow  out  4  per-lane sticky drop flag, registered.

Behaviour:
- Reset (default_values=0 at an edge):
  - all FIFO pointers and counts = 0; round-robin pointer rr = 0.
  - data_out = IDLE_BYTE, valid_out = 0, grant = 0, overflow = 0, so full = 0.
  - Reset wins over every simultaneous push and pop. Reset mid-stream discards all FIFO contents.
- Push:
  - At an edge with valid_inN=1 and countN<FIFO_DEPTH, the byte is written at the tail.
  - If countN==FIFO_DEPTH, the byte is dropped and overflow[N] is set to 1. It stays 1 until reset.
  - Full is evaluated on the count before the edge: a push to a full FIFO is dropped even if that FIFO is popped in the same cycle.
- Pop/arbitration, evaluated each edge:
  - If ready=1 and at least one FIFO is non-empty (count before the edge >0): select the first non-empty lane scanning rr, rr+1, rr+2, rr+3 (mod 4).
  - On selection:
    - data_out <= head of the selected lane; valid_out <= 1; grant <= lane.
    - That lane's FIFO pops.
    - rr <= lane+1 (mod 4).
  - If ready=0 or all FIFOs are empty: valid_out <= 0, data_out <= IDLE_BYTE, grant and rr hold, no pop.
- There is no write-to-read bypass. A byte pushed at edge k is eligible for selection at edge k+1 and appears on data_out after edge k+1, giving a minimum latency of 2 edges from valid_in to valid_out.
- Simultaneous push and pop on the same lane: both occur, and the count is unchanged.
- Pointer wrap-around: head and tail wrap modulo FIFO_DEPTH. Count width is log2(FIFO_DEPTH)+1.
- Fairness: with all four lanes continuously backlogged and ready=1, grant sequence is 0,1,2,3,0,… One byte is output per cycle.
- Ordering: bytes within a lane are emitted in arrival order. Across lanes there is no ordering guarantee beyond round-robin.

Test Plan:
- Reset: hold default_values=0 for 2 edges with valid_in0..3=1 → valid_out=0, data_out=8'hBC, grant=0, full=4'b0000, overflow=4'b0000; nothing is emitted after release until new pushes arrive.
- Single lane: push 8'h11, 8'h22, 8'h33 on lane 2 with ready=1 → valid_out is 1 on three consecutive cycles, starting 2 edges after the first push, with data_out 11,22,33 and grant=2; then idle 8'hBC.
- Fairness: preload each lane n with bytes {n0,n1}, i.e. 8'h00,8'h01 / 8'h10,8'h11 / …, then ready=1 → output 00,10,20,30,01,11,21,31 with grant 0,1,2,3,0,1,2,3.
- Backpressure/overflow: ready=0, push 5 bytes on lane 1 with FIFO_DEPTH=4 → full[1]=1 after the 4th, 5th byte dropped, overflow[1]=1; then ready=1 → exactly the first 4 bytes out, in order; overflow[1] remains 1.
- Full plus same-cycle pop: lane 0 full, ready=1, push 8'hAA in the cycle lane 0 is granted → 8'hAA dropped and overflow[0]=1; count becomes 3.
- Reset mid-operation: with lanes 0 and 3 half full and output streaming, assert default_values for 1 edge → next cycle valid_out=0, data_out=8'hBC, rr=0; no pre-reset byte is ever emitted.

Source files
------------

// File: rtl/phy_lane_arbiter.sv
`default_nettype none
// phy_lane_arbiter: four per-lane byte FIFOs merged round-robin onto one registered stream.
// Rev 1.0
module phy_lane_arbiter #(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    FIFO_DEPTH = 4,
  parameter logic [DATA_WIDTH-1:0] IDLE_BYTE  = 'hBC
) (
  input  logic                  clk_4f,
  input  logic                  default_values,
  input  logic [DATA_WIDTH-1:0] data_in0,
  input  logic [DATA_WIDTH-1:0] data_in1,
  input  logic [DATA_WIDTH-1:0] data_in2,
  input  logic [DATA_WIDTH-1:0] data_in3,
  input  logic                  valid_in0,
  input  logic                  valid_in1,
  input  logic                  valid_in2,
  input  logic                  valid_in3,
  input  logic                  ready,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic [1:0]            grant,
  output logic [3:0]            full,
  output logic [3:0]            overflow
);

  localparam int c_NL = 4;
  localparam int c_AW = $clog2(FIFO_DEPTH);
  localparam int c_CW = c_AW + 1;

  logic [DATA_WIDTH-1:0] w_din       [c_NL];
  logic [DATA_WIDTH-1:0] w_head_data [c_NL];
  logic [c_NL-1:0]       w_vin;
  logic [c_NL-1:0]       w_full;
  logic [c_NL-1:0]       w_nonempty;
  logic [c_NL-1:0]       w_push;
  logic [c_NL-1:0]       w_drop;
  logic [c_NL-1:0]       w_pop;
  logic [1:0]            w_sel;
  logic                  w_any;
  logic                  w_take;
  logic [1:0]            r_rr;

  assign w_din[0] = data_in0;
  assign w_din[1] = data_in1;
  assign w_din[2] = data_in2;
  assign w_din[3] = data_in3;
  assign w_vin    = {valid_in3, valid_in2, valid_in1, valid_in0};

  generate
    for (genvar n = 0; n < c_NL; n++) begin : g_lane
      logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
      logic [c_AW-1:0]       r_head;
      logic [c_AW-1:0]       r_tail;
      logic [c_CW-1:0]       r_count;

      // Full is judged on the pre-edge count, so a same-cycle pop never makes room.
      assign w_full[n]      = (r_count == c_CW'(FIFO_DEPTH));
      assign w_nonempty[n]  = (r_count != '0);
      assign w_head_data[n] = r_mem[r_head];
      assign w_push[n]      = w_vin[n] & ~w_full[n];
      assign w_drop[n]      = w_vin[n] &  w_full[n];

      always_ff @(posedge clk_4f) begin
        if (!default_values) begin
          r_head  <= '0;
          r_tail  <= '0;
          r_count <= '0;
        end else begin
          if (w_push[n]) begin
            r_mem[r_tail] <= w_din[n];
            r_tail        <= r_tail + c_AW'(1);
          end
          if (w_pop[n]) begin
            r_head <= r_head + c_AW'(1);
          end
          case ({w_push[n], w_pop[n]})
            2'b10:   r_count <= r_count + c_CW'(1);
            2'b01:   r_count <= r_count - c_CW'(1);
            default: r_count <= r_count;
          endcase
        end
      end
    end
  endgenerate

  // Scan from the far end back toward r_rr so the nearest non-empty lane wins.
  always_comb begin
    w_any = 1'b0;
    w_sel = r_rr;
    for (int i = c_NL - 1; i >= 0; i--) begin
      if (w_nonempty[r_rr + 2'(i)]) begin
        w_any = 1'b1;
        w_sel = r_rr + 2'(i);
      end
    end
  end

  assign w_take = ready & w_any;
  assign w_pop  = w_take ? (4'b0001 << w_sel) : 4'b0000;
  assign full   = w_full;

  always_ff @(posedge clk_4f) begin
    if (!default_values) begin
      data_out  <= IDLE_BYTE;
      valid_out <= 1'b0;
      grant     <= 2'd0;
      r_rr      <= 2'd0;
      overflow  <= 4'b0000;
    end else begin
      overflow <= overflow | w_drop;
      if (w_take) begin
        data_out  <= w_head_data[w_sel];
        valid_out <= 1'b1;
        grant     <= w_sel;
        r_rr      <= w_sel + 2'd1;
      end else begin
        data_out  <= IDLE_BYTE;
        valid_out <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_phy_lane_arbiter.sv
`default_nettype none
// tb_phy_lane_arbiter: directed stimulus with a queue scoreboard and a free-running output monitor.
// Rev 1.0
module tb_phy_lane_arbiter;

  logic       clk_4f = 1'b0;
  logic       default_values;
  logic [7:0] d0, d1, d2, d3;
  logic       v0, v1, v2, v3;
  logic       ready;
  logic [7:0] data_out;
  logic       valid_out;
  logic [1:0] grant;
  logic [3:0] full;
  logic [3:0] overflow;

  phy_lane_arbiter #(
    .DATA_WIDTH (8),
    .FIFO_DEPTH (4),
    .IDLE_BYTE  (8'hBC)
  ) dut (
    .clk_4f         (clk_4f),
    .default_values (default_values),
    .data_in0       (d0),
    .data_in1       (d1),
    .data_in2       (d2),
    .data_in3       (d3),
    .valid_in0      (v0),
    .valid_in1      (v1),
    .valid_in2      (v2),
    .valid_in3      (v3),
    .ready          (ready),
    .data_out       (data_out),
    .valid_out      (valid_out),
    .grant          (grant),
    .full           (full),
    .overflow       (overflow)
  );

  always #5 clk_4f = ~clk_4f;

  typedef struct packed {
    logic [7:0] d;
    logic [1:0] g;
  } exp_t;

  exp_t q[$];
  int   n_pass  = 0;
  int   n_total = 0;
  bit   mon_en  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
  endtask

  task automatic exp_push(input logic [7:0] d, input logic [1:0] g);
    exp_t e;
    e.d = d;
    e.g = g;
    q.push_back(e);
  endtask

  // Output monitor: every valid byte must match the head of the scoreboard queue.
  always @(negedge clk_4f) begin
    if (mon_en) begin
      if (valid_out === 1'b1) begin
        if (q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_output: got data %h grant %0d, required no output at %0t",
                   data_out, grant, $time);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("out_data", {24'd0, data_out}, {24'd0, e.d});
          chk("out_grant", {30'd0, grant}, {30'd0, e.g});
        end
      end else begin
        chk("idle_valid", {31'd0, valid_out}, 32'd0);
        chk("idle_data", {24'd0, data_out}, 32'hBC);
      end
    end
  end

  task automatic tick();
    @(posedge clk_4f);
    #2;
  endtask

  task automatic clr_in();
    v0 = 1'b0; v1 = 1'b0; v2 = 1'b0; v3 = 1'b0;
  endtask

  task automatic set_lane(input int n, input logic [7:0] d);
    case (n)
      0: begin d0 = d; v0 = 1'b1; end
      1: begin d1 = d; v1 = 1'b1; end
      2: begin d2 = d; v2 = 1'b1; end
      default: begin d3 = d; v3 = 1'b1; end
    endcase
  endtask

  task automatic do_reset(input int cycles);
    default_values = 1'b0;
    repeat (cycles) tick();
    default_values = 1'b1;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 20; i++) begin
      if (q.size() == 0) break;
      tick();
    end
    chk({name, "_drained"}, q.size(), 32'd0);
  endtask

  task automatic chk_reset_state(input string name);
    chk({name, "_valid"}, {31'd0, valid_out}, 32'd0);
    chk({name, "_data"}, {24'd0, data_out}, 32'hBC);
    chk({name, "_grant"}, {30'd0, grant}, 32'd0);
    chk({name, "_full"}, {28'd0, full}, 32'd0);
    chk({name, "_overflow"}, {28'd0, overflow}, 32'd0);
  endtask

  initial begin
    default_values = 1'b0;
    ready = 1'b1;
    d0 = 8'hA0; d1 = 8'hA1; d2 = 8'hA2; d3 = 8'hA3;
    v0 = 1'b1; v1 = 1'b1; v2 = 1'b1; v3 = 1'b1;

    // Reset held two edges while every lane pushes: nothing may be stored.
    tick();
    mon_en = 1'b1;
    tick();
    chk_reset_state("reset");
    default_values = 1'b1;
    clr_in();
    repeat (6) tick();

    // Single lane, two-edge latency.
    exp_push(8'h11, 2'd2);
    exp_push(8'h22, 2'd2);
    exp_push(8'h33, 2'd2);
    set_lane(2, 8'h11);
    tick();
    chk("latency_not_yet", {31'd0, valid_out}, 32'd0);
    set_lane(2, 8'h22);
    tick();
    chk("latency_first", {31'd0, valid_out}, 32'd1);
    set_lane(2, 8'h33);
    tick();
    clr_in();
    tick();
    chk("single_third", {24'd0, data_out}, 32'h33);
    drain("single");
    repeat (3) tick();

    // Fairness: two bytes per lane, round robin from lane 0.
    do_reset(1);
    ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      for (int n = 0; n < 4; n++) set_lane(n, 8'(n * 16 + k));
      tick();
    end
    clr_in();
    chk("fair_preload_full", {28'd0, full}, 32'd0);
    for (int k = 0; k < 2; k++)
      for (int n = 0; n < 4; n++) exp_push(8'(n * 16 + k), 2'(n));
    ready = 1'b1;
    repeat (8) tick();
    @(negedge clk_4f);
    #1;
    chk("fair_one_per_cycle", q.size(), 32'd0);
    drain("fair");
    repeat (3) tick();

    // Backpressure and overflow on lane 1.
    do_reset(1);
    ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_lane(1, 8'h51 + 8'(i));
      tick();
      if (i == 2) chk("bp_not_full_at3", {28'd0, full}, 32'h0);
      if (i == 3) begin
        chk("bp_full_at4", {28'd0, full}, 32'h2);
        chk("bp_no_ovf_at4", {28'd0, overflow}, 32'h0);
      end
    end
    clr_in();
    chk("bp_full_at5", {28'd0, full}, 32'h2);
    chk("bp_ovf_at5", {28'd0, overflow}, 32'h2);
    for (int i = 0; i < 4; i++) exp_push(8'h51 + 8'(i), 2'd1);
    ready = 1'b1;
    drain("bp");
    repeat (3) tick();
    chk("bp_ovf_sticky", {28'd0, overflow}, 32'h2);
    chk("bp_full_clear", {28'd0, full}, 32'h0);

    // Push into a full lane 0 on the same edge it is popped: dropped.
    do_reset(1);
    ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_lane(0, 8'h61 + 8'(i));
      tick();
    end
    clr_in();
    chk("fp_full", {28'd0, full}, 32'h1);
    for (int i = 0; i < 4; i++) exp_push(8'h61 + 8'(i), 2'd0);
    ready = 1'b1;
    set_lane(0, 8'hAA);
    tick();
    clr_in();
    chk("fp_count3_not_full", {28'd0, full}, 32'h0);
    chk("fp_ovf", {28'd0, overflow}, 32'h1);
    drain("fp");
    repeat (3) tick();

    // Reset mid-stream: lanes 0 and 3 half full, rr left at 1 by the previous test.
    ready = 1'b0;
    set_lane(0, 8'h70);
    set_lane(3, 8'h73);
    tick();
    set_lane(0, 8'h71);
    set_lane(3, 8'h74);
    tick();
    clr_in();
    exp_push(8'h73, 2'd3);
    exp_push(8'h70, 2'd0);
    ready = 1'b1;
    tick();
    tick();
    default_values = 1'b0;
    tick();
    default_values = 1'b1;
    chk_reset_state("midrst");
    chk("midrst_queue", q.size(), 32'd0);
    repeat (5) tick();
    exp_push(8'h80, 2'd0);
    exp_push(8'h81, 2'd1);
    set_lane(0, 8'h80);
    set_lane(1, 8'h81);
    tick();
    clr_in();
    drain("midrst_rr");
    repeat (4) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
